// File: rtl/inst_fetcher_pkg.sv
// Shared fetch types, line geometry, reset values and FSM state encoding.
// FETCH_LINE_REUSE_EN (see inst_fetcher) is the only build option.
package inst_fetcher_pkg;
  typedef logic [31:0] ADDR_TYPE;
  typedef logic [31:0] INST_TYPE;

  localparam int LINE_WORDS = 4;
  localparam int IDX_W      = $clog2(LINE_WORDS);
  localparam int TAG_W      = 28;

  localparam INST_TYPE INST_RESET = 32'h0000_0000;
  localparam ADDR_TYPE ADDR_RESET = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_FILL    = 3'd2,
    S_RELEASE = 3'd3,
    S_ISSUE   = 3'd4
  } fetch_state_t;

  function automatic logic [TAG_W-1:0] line_tag(input ADDR_TYPE addr);
    return addr[31:4];
  endfunction
endpackage

// File: rtl/fetch_line_buf.sv
// One-line instruction store: 4x32 slots, single write port, indexed read, tag/valid.
// Writes land on the clock edge; read and hit are combinational. No backpressure.
module fetch_line_buf
  import inst_fetcher_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_dat,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_dat,
  input  logic             set_valid,
  input  logic             clr_valid,
  input  logic [TAG_W-1:0] set_tag,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             hit
);
  INST_TYPE         slot [LINE_WORDS];
  logic [TAG_W-1:0] tag;
  logic             line_valid;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < LINE_WORDS; i++) slot[i] <= INST_RESET;
      tag        <= '0;
      line_valid <= 1'b0;
    end else begin
      if (wr_en) slot[wr_idx] <= wr_dat;
      if (clr_valid) begin
        line_valid <= 1'b0;
      end else if (set_valid) begin
        line_valid <= 1'b1;
        tag        <= set_tag;
      end
    end
  end

  assign rd_dat = slot[rd_idx];
  assign hit    = line_valid && (tag == lookup_tag);
endmodule

// File: rtl/inst_fetcher.sv
// Line-based instruction fetcher: request = controller latency + 2 cycles to first issue, then 1/cycle.
// rdy_in=0 freezes everything; issue holds while issue_ready_in=0. FETCH_LINE_REUSE_EN enables line reuse.
module inst_fetcher
  import inst_fetcher_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        mem_enable_out,
  output logic [31:0] mem_addr_out,
  output logic        mem_reset_out,
  input  logic        mem_avail_in,
  input  logic        mem_word_done_in,
  input  logic [31:0] mem_inst_in,
  input  logic        mem_end_in,
  input  logic        jump_in,
  input  logic [31:0] jump_pc_in,
  input  logic        issue_ready_in,
  output logic        inst_valid_out,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out
);
  fetch_state_t state, state_nxt;
  ADDR_TYPE     pc, pc_nxt, addr_nxt;
  logic         en_nxt, rst_pulse_nxt;
  logic         cap_pend, cap_nxt;
  logic [2:0]   wr_cnt, wr_cnt_nxt, pulse_cnt, pulse_nxt;
  logic         filling;
  logic         buf_wr, buf_set, buf_clr, buf_hit, reuse_hit;
  INST_TYPE     rd_dat;

  fetch_line_buf u_line_buf (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .wr_en      (buf_wr & rdy_in),
    .wr_idx     (wr_cnt[IDX_W-1:0]),
    .wr_dat     (mem_inst_in),
    .rd_idx     (pc[3:2]),
    .rd_dat     (rd_dat),
    .set_valid  (buf_set & rdy_in),
    .clr_valid  (buf_clr & rdy_in),
    .set_tag    (line_tag(pc)),
    .lookup_tag (line_tag(pc)),
    .hit        (buf_hit)
  );

`ifdef FETCH_LINE_REUSE_EN
  assign reuse_hit = buf_hit;
`else
  // Tag compare is still built but never allowed to bypass the memory request.
  assign reuse_hit = 1'b0 & buf_hit;
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state          <= S_IDLE;
      pc             <= ADDR_RESET;
      mem_enable_out <= 1'b0;
      mem_addr_out   <= ADDR_RESET;
      mem_reset_out  <= 1'b0;
      cap_pend       <= 1'b0;
      wr_cnt         <= 3'd0;
      pulse_cnt      <= 3'd0;
    end else if (rdy_in) begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      mem_enable_out <= en_nxt;
      mem_addr_out   <= addr_nxt;
      mem_reset_out  <= rst_pulse_nxt;
      cap_pend       <= cap_nxt;
      wr_cnt         <= wr_cnt_nxt;
      pulse_cnt      <= pulse_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    en_nxt        = mem_enable_out;
    addr_nxt      = mem_addr_out;
    rst_pulse_nxt = 1'b0;
    cap_nxt       = 1'b0;
    wr_cnt_nxt    = wr_cnt;
    pulse_nxt     = pulse_cnt;
    buf_wr        = 1'b0;
    buf_set       = 1'b0;
    buf_clr       = 1'b0;
    filling       = (state == S_REQ) || (state == S_FILL) || (state == S_RELEASE);

    if (jump_in) begin
      pc_nxt     = jump_pc_in;
      state_nxt  = S_IDLE;
      wr_cnt_nxt = 3'd0;
      pulse_nxt  = 3'd0;
      if (filling) begin
        buf_clr = 1'b1;
        en_nxt  = 1'b0;
        // Controller is only still counting while the request is held.
        rst_pulse_nxt = (state != S_RELEASE);
      end
    end else begin
      // Word data arrives one cycle after its done pulse.
      if (filling && cap_pend) begin
        buf_wr     = 1'b1;
        wr_cnt_nxt = wr_cnt + 3'd1;
      end
      if (filling && mem_word_done_in && (pulse_cnt < 3'd4)) begin
        cap_nxt   = 1'b1;
        pulse_nxt = pulse_cnt + 3'd1;
      end

      case (state)
        S_IDLE: begin
          if (reuse_hit) begin
            state_nxt = S_ISSUE;
          end else if (mem_avail_in) begin
            state_nxt  = S_REQ;
            en_nxt     = 1'b1;
            addr_nxt   = {line_tag(pc), 4'b0000};
            buf_clr    = 1'b1;
            wr_cnt_nxt = 3'd0;
            pulse_nxt  = 3'd0;
          end
        end
        S_REQ: begin
          if (mem_word_done_in) state_nxt = S_FILL;
        end
        S_FILL: begin
          if (mem_end_in && (pulse_nxt == 3'd4)) begin
            state_nxt = S_RELEASE;
            en_nxt    = 1'b0;
          end
        end
        S_RELEASE: begin
          if (wr_cnt_nxt == 3'd4) begin
            state_nxt = S_ISSUE;
            buf_set   = 1'b1;
          end
        end
        S_ISSUE: begin
          if (issue_ready_in) begin
            pc_nxt = pc + 32'd4;
            if (pc[3:2] == 2'd3) state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign inst_valid_out = (state == S_ISSUE);
  assign inst_out       = inst_valid_out ? rd_dat : INST_RESET;
  assign pc_out         = inst_valid_out ? pc : ADDR_RESET;
endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: behavioural memory controller, instruction-stream scoreboard, directed + random phases.
module tb_inst_fetcher;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        mem_enable_out, mem_reset_out, mem_avail_in, mem_word_done_in, mem_end_in;
  logic        jump_in, issue_ready_in, inst_valid_out;
  logic [31:0] mem_addr_out, mem_inst_in, jump_pc_in, inst_out, pc_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_in = ~clk_in;

  inst_fetcher dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .mem_enable_out   (mem_enable_out),
    .mem_addr_out     (mem_addr_out),
    .mem_reset_out    (mem_reset_out),
    .mem_avail_in     (mem_avail_in),
    .mem_word_done_in (mem_word_done_in),
    .mem_inst_in      (mem_inst_in),
    .mem_end_in       (mem_end_in),
    .jump_in          (jump_in),
    .jump_pc_in       (jump_pc_in),
    .issue_ready_in   (issue_ready_in),
    .inst_valid_out   (inst_valid_out),
    .inst_out         (inst_out),
    .pc_out           (pc_out)
  );

  // Memory image: line 0 holds addi x0..x3 encodings, other addresses stay distinguishable.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[13:2], a[24:14], a[3:2], 7'h13};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Behavioural memory controller
  logic        b_act, b_dat_pend;
  int          b_wait, b_k, b_cool;
  logic [31:0] b_base, b_dat_addr;

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      b_act <= 1'b0; b_dat_pend <= 1'b0; b_wait <= 0; b_k <= 0; b_cool <= 2;
      b_base <= '0; b_dat_addr <= '0;
      mem_avail_in <= 1'b0; mem_word_done_in <= 1'b0; mem_end_in <= 1'b0; mem_inst_in <= '0;
    end else if (rdy_in) begin
      mem_word_done_in <= 1'b0;
      mem_inst_in      <= $urandom;
      if (b_dat_pend) mem_inst_in <= word_at(b_dat_addr);
      b_dat_pend <= 1'b0;
      if (!b_act) begin
        mem_end_in <= 1'b0;
        if (b_cool > 0) begin
          b_cool       <= b_cool - 1;
          mem_avail_in <= 1'b0;
        end else if (mem_enable_out && mem_avail_in) begin
          b_act        <= 1'b1;
          b_base       <= mem_addr_out;
          b_k          <= 0;
          b_wait       <= int'($urandom_range(1, 4));
          mem_avail_in <= 1'b0;
        end else begin
          mem_avail_in <= 1'b1;
        end
      end else if (mem_reset_out || (!mem_enable_out && b_k == 4)) begin
        b_act      <= 1'b0;
        mem_end_in <= 1'b0;
        b_cool     <= int'($urandom_range(1, 3));
      end else if (b_wait > 0) begin
        b_wait <= b_wait - 1;
      end else if (b_k < 4) begin
        mem_word_done_in <= 1'b1;
        b_dat_addr       <= b_base + 32'(b_k * 4);
        b_dat_pend       <= 1'b1;
        b_k              <= b_k + 1;
        b_wait           <= int'($urandom_range(0, 2));
      end else begin
        mem_end_in <= 1'b1;
      end
    end
  end

  // Scoreboard: the architectural pc stream and request/abort rules
  logic [31:0] m_pc, req_addr;
  logic        l_jump, l_jump_en, l_rdy, exp_rst, prev_en;
  int          n_hs = 0;

  always @(negedge clk_in) begin
    if (!rst_in) begin
      m_pc = 32'h0; req_addr = 32'h0; exp_rst = 1'b0; prev_en = 1'b0;
      l_jump = 1'b0; l_jump_en = 1'b0; l_rdy = 1'b0;
    end else begin
      if (l_rdy) exp_rst = l_jump_en;
      check("mem_reset", {31'b0, mem_reset_out}, {31'b0, exp_rst});
      if (l_jump) check("valid_after_jump", {31'b0, inst_valid_out}, 32'h0);
      if (mem_enable_out && !prev_en) begin
        req_addr = {m_pc[31:4], 4'h0};
        check("req_addr", mem_addr_out, req_addr);
      end else if (mem_enable_out) begin
        check("addr_stable", mem_addr_out, req_addr);
      end
      if (inst_valid_out) begin
        check("pc_out", pc_out, m_pc);
        check("inst_out", inst_out, word_at(m_pc));
      end
      prev_en   = mem_enable_out;
      l_rdy     = rdy_in;
      l_jump    = rdy_in && jump_in;
      l_jump_en = rdy_in && jump_in && mem_enable_out;
      if (rdy_in && jump_in) begin
        m_pc = jump_pc_in;
      end else if (rdy_in && inst_valid_out && issue_ready_in) begin
        m_pc = m_pc + 32'd4;
        n_hs++;
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // which: 0 inst valid, 1 request raised, 2 two words sent, 3 one word sent
  task automatic wait_on(input int which, input string tag);
    int  n;
    bit  hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 400) begin
      case (which)
        0:       hit = inst_valid_out;
        1:       hit = mem_enable_out;
        2:       hit = b_act && (b_k == 2);
        default: hit = b_act && (b_k == 1);
      endcase
      if (!hit) begin
        tick();
        n++;
      end
    end
    check(tag, {31'b0, hit}, 32'h1);
  endtask

  task automatic do_jump(input logic [31:0] target);
    jump_in    = 1'b1;
    jump_pc_in = target;
    tick();
    jump_in = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"},    {31'b0, mem_enable_out}, 32'h0);
    check({tag, "_addr"},  mem_addr_out, 32'h0);
    check({tag, "_mrst"},  {31'b0, mem_reset_out}, 32'h0);
    check({tag, "_valid"}, {31'b0, inst_valid_out}, 32'h0);
    check({tag, "_inst"},  inst_out, 32'h0);
    check({tag, "_pc"},    pc_out, 32'h0);
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; jump_in = 1'b0; jump_pc_in = '0; issue_ready_in = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_in = 1'b1;

    // Cold fetch of line 0, four back-to-back issues, then the next line
    wait_on(0, "first_valid");
    for (int i = 0; i < 4; i++) begin
      check("line0_valid", {31'b0, inst_valid_out}, 32'h1);
      check("line0_pc", pc_out, 32'(i * 4));
      tick();
    end
    wait_on(1, "req_0x10");
    check("req_0x10_addr", mem_addr_out, 32'h10);

    // Mid-line target: issue starts at slot 2
    do_jump(32'h108);
    check("j108_abort_en", {31'b0, mem_enable_out}, 32'h0);
    check("j108_abort_pulse", {31'b0, mem_reset_out}, 32'h1);
    wait_on(1, "req_0x100");
    check("req_0x100_addr", mem_addr_out, 32'h100);
    wait_on(0, "valid_108");
    check("pc_108", pc_out, 32'h108);
    tick();
    check("pc_10c", pc_out, 32'h10C);
    tick();
    wait_on(1, "req_0x110");
    check("req_0x110_addr", mem_addr_out, 32'h110);

    // Jump during fill after two words
    wait_on(2, "two_words");
    tick();
    do_jump(32'h100);
    check("jfill_en", {31'b0, mem_enable_out}, 32'h0);
    check("jfill_pulse", {31'b0, mem_reset_out}, 32'h1);
    tick();
    check("jfill_pulse_end", {31'b0, mem_reset_out}, 32'h0);
    issue_ready_in = 1'b0;
    wait_on(1, "req_after_jfill");
    check("req_after_jfill_addr", mem_addr_out, 32'h100);
    wait_on(0, "valid_100");
    check("pc_100", pc_out, 32'h100);

    // Decoder stall holds the instruction
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", {31'b0, inst_valid_out}, 32'h1);
      check("stall_pc", pc_out, 32'h100);
      check("stall_inst", inst_out, word_at(32'h100));
    end

    // Jump into the resident line
    do_jump(32'h104);
`ifdef FETCH_LINE_REUSE_EN
    check("reuse_no_req0", {31'b0, mem_enable_out}, 32'h0);
    tick();
    check("reuse_no_req1", {31'b0, mem_enable_out}, 32'h0);
    check("reuse_valid", {31'b0, inst_valid_out}, 32'h1);
    check("reuse_pc", pc_out, 32'h104);
`else
    wait_on(1, "noreuse_req");
    check("noreuse_req_addr", mem_addr_out, 32'h100);
    wait_on(0, "noreuse_valid");
    check("noreuse_pc", pc_out, 32'h104);
`endif
    issue_ready_in = 1'b1;
    wait_on(1, "req_after_104");
    check("req_after_104_addr", mem_addr_out, 32'h110);

    // Address wrap at the top of memory
    do_jump(32'hFFFF_FFF8);
    wait_on(1, "req_top");
    check("req_top_addr", mem_addr_out, 32'hFFFF_FFF0);
    wait_on(0, "valid_top");
    check("pc_top", pc_out, 32'hFFFF_FFF8);
    tick();
    check("pc_topc", pc_out, 32'hFFFF_FFFC);
    tick();
    wait_on(1, "req_wrap");
    check("req_wrap_addr", mem_addr_out, 32'h0);

    // Reset in the middle of a fill
    wait_on(3, "one_word");
    tick();
    rst_in = 1'b0;
    #1;
    check_reset_outputs("midfill_rst");
    tick();
    rst_in = 1'b1;
    wait_on(1, "req_after_rst");
    check("req_after_rst_addr", mem_addr_out, 32'h0);

    // Random traffic: stalls, decoder backpressure, redirects
    for (int i = 0; i < 3000; i++) begin
      issue_ready_in = ($urandom_range(0, 3) != 0);
      rdy_in         = ($urandom_range(0, 9) != 0);
      jump_in        = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0)
        jump_pc_in = 32'hFFFF_FFC0 | {26'b0, 4'(($urandom_range(0, 15))), 2'b00};
      else
        jump_pc_in = {24'b0, 6'(($urandom_range(0, 63))), 2'b00};
      tick();
    end
    jump_in = 1'b0;
    rdy_in  = 1'b1;
    repeat (5) tick();
    check("progress", {31'b0, (n_hs > 200)}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
